// File: rtl/openpiton_flit_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : openpiton_flit_deserializer_pkg
// Purpose  : Shared constants and types for the xctcmsg OpenPiton flit
//            serializer/deserializer pair.
// Revision : 1.0 - initial release
// ============================================================================
package openpiton_flit_deserializer_pkg;

    // Physical OpenPiton flit width; the message header is exactly one flit.
    localparam int XCTCMSG_FLIT_WIDTH         = 64;
    localparam int XCTCMSG_MSG_HEADER_WIDTH   = XCTCMSG_FLIT_WIDTH;

    // Number of payload flits following each header.
    localparam int XCTCMSG_MSG_PAYLOAD_LENGTH = 2;
    localparam int XCTCMSG_MSG_PAYLOAD_WIDTH  = XCTCMSG_MSG_PAYLOAD_LENGTH * XCTCMSG_FLIT_WIDTH;

    // Location of the message length field within the header flit.
    localparam int XCTCMSG_MSG_LENGTH_LSB     = 22;
    localparam int XCTCMSG_MSG_LENGTH_WIDTH   = 8;

    // Assembled word handed to the adapter: {payload, header}.
    localparam int PITON_XCTCMSG_NOC_WIDTH    = XCTCMSG_MSG_HEADER_WIDTH + XCTCMSG_MSG_PAYLOAD_WIDTH;

    // Deserializer control states.
    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_FULL    = 2'd3
    } deser_state_t;

endpackage : openpiton_flit_deserializer_pkg
`default_nettype wire

// File: rtl/openpiton_flit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : openpiton_flit_deserializer
// Purpose  : Collects a header flit plus its payload flits from the OpenPiton
//            router port and presents them as one {payload, header} word to
//            the adapter. Headers with a wrong length are flagged and the
//            announced flits are discarded.
// Revision : 1.0 - initial release
// ============================================================================
module openpiton_flit_deserializer
    import openpiton_flit_deserializer_pkg::*;
#(
    parameter int FLIT_WIDTH    = XCTCMSG_FLIT_WIDTH,
    parameter int PAYLOAD_FLITS = XCTCMSG_MSG_PAYLOAD_LENGTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flit_in_val,
    output logic                                   flit_in_rdy,
    input  logic [FLIT_WIDTH-1:0]                  flit_in_data,
    output logic                                   noc_out_val,
    input  logic                                   noc_out_rdy,
    output logic [(PAYLOAD_FLITS+1)*FLIT_WIDTH-1:0] noc_out_data,
    output logic                                   err_length
);

    localparam int LEN_W = XCTCMSG_MSG_LENGTH_WIDTH;
    localparam int CNT_W = (PAYLOAD_FLITS > 0) ? $clog2(PAYLOAD_FLITS + 1) : 1;

    localparam logic [LEN_W-1:0] C_PAYLOAD_LEN = LEN_W'(PAYLOAD_FLITS);
    localparam logic [CNT_W-1:0] C_LAST_SLOT   = CNT_W'(PAYLOAD_FLITS - 1);

    deser_state_t            state;
    deser_state_t            state_next;
    logic [FLIT_WIDTH-1:0]   header;
    logic [CNT_W-1:0]        cnt;
    logic [LEN_W-1:0]        drop;
    logic [LEN_W-1:0]        len;
    logic                    flit_xfer;
    logic                    hdr_xfer;
    logic                    hdr_load;
    logic                    cnt_clr;
    logic                    drop_load;
    logic                    err_set;

    // In FULL the router is only accepted while the word is leaving, so a new
    // header can overlap the output transfer without a bubble.
    assign flit_in_rdy = (state != ST_FULL) || noc_out_rdy;
    assign noc_out_val = (state == ST_FULL);

    assign flit_xfer = flit_in_val && flit_in_rdy;
    assign hdr_xfer  = flit_xfer && ((state == ST_HEADER) || (state == ST_FULL));
    assign len       = flit_in_data[XCTCMSG_MSG_LENGTH_LSB +: LEN_W];

    // Next-state decode; header handling is shared by HEADER and FULL.
    always_comb begin
        state_next = state;
        hdr_load   = 1'b0;
        cnt_clr    = 1'b0;
        drop_load  = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_HEADER: ;
            ST_FULL: begin
                if (noc_out_rdy) begin
                    state_next = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (flit_xfer && (cnt == C_LAST_SLOT)) begin
                    state_next = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (flit_xfer && (drop == LEN_W'(1))) begin
                    state_next = ST_HEADER;
                end
            end
            default: state_next = ST_HEADER;
        endcase
        if (hdr_xfer) begin
            if (len == C_PAYLOAD_LEN) begin
                hdr_load = 1'b1;
                if (PAYLOAD_FLITS != 0) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_PAYLOAD;
                end else begin
                    state_next = ST_FULL;
                end
            end else begin
                err_set = 1'b1;
                if (len == '0) begin
                    state_next = ST_HEADER;
                end else begin
                    drop_load  = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
        end
    end

    // State register and registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HEADER;
            err_length <= 1'b0;
        end else begin
            state      <= state_next;
            err_length <= err_set;
        end
    end

    // Header capture and payload slot / drop counters; both reload per header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header <= '0;
            cnt    <= '0;
            drop   <= '0;
        end else begin
            if (hdr_load) begin
                header <= flit_in_data;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if ((state == ST_PAYLOAD) && flit_xfer) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (drop_load) begin
                drop <= len;
            end else if ((state == ST_DRAIN) && flit_xfer) begin
                drop <= drop - LEN_W'(1);
            end
        end
    end

    assign noc_out_data[FLIT_WIDTH-1:0] = header;

    // One register per payload slot; flit k lands in slot k-1 above the header.
    for (genvar i = 0; i < PAYLOAD_FLITS; i++) begin : g_slot
        logic [FLIT_WIDTH-1:0] slot;
        logic                  slot_we;

        assign slot_we = (state == ST_PAYLOAD) && flit_xfer && (cnt == CNT_W'(i));

        // Capture the payload flit addressed to this slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot <= '0;
            end else if (slot_we) begin
                slot <= flit_in_data;
            end
        end

        assign noc_out_data[(i+1)*FLIT_WIDTH +: FLIT_WIDTH] = slot;
    end : g_slot

endmodule : openpiton_flit_deserializer
`default_nettype wire

// File: tb/tb_openpiton_flit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_openpiton_flit_deserializer
// Purpose  : Directed scoreboard bench for openpiton_flit_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_openpiton_flit_deserializer;
    import openpiton_flit_deserializer_pkg::*;

    localparam int FW = 64;
    localparam int NP = 2;
    localparam int WW = FW * (NP + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flit_in_val = 1'b0;
    logic          flit_in_rdy;
    logic [FW-1:0] flit_in_data = '0;
    logic          noc_out_val;
    logic          noc_out_rdy = 1'b1;
    logic [WW-1:0] noc_out_data;
    logic          err_length;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_seen = 0;
    logic [WW-1:0] exp_q[$];
    int            pop_cyc[$];

    openpiton_flit_deserializer #(
        .FLIT_WIDTH    (FW),
        .PAYLOAD_FLITS (NP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flit_in_val  (flit_in_val),
        .flit_in_rdy  (flit_in_rdy),
        .flit_in_data (flit_in_data),
        .noc_out_val  (noc_out_val),
        .noc_out_rdy  (noc_out_rdy),
        .noc_out_data (noc_out_data),
        .err_length   (err_length)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_hdr(input int len, input logic [15:0] tag);
        logic [FW-1:0] h;
        h = 64'hC0DE_0000_0000_0000;
        h[XCTCMSG_MSG_LENGTH_LSB +: XCTCMSG_MSG_LENGTH_WIDTH] = XCTCMSG_MSG_LENGTH_WIDTH'(len);
        h[15:0] = tag;
        return h;
    endfunction

    // Present one flit and hold it until the DUT accepts it.
    task automatic send(input logic [FW-1:0] d);
        int n;
        n = 0;
        flit_in_val  = 1'b1;
        flit_in_data = d;
        @(negedge clk);
        while (!flit_in_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!flit_in_rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: flit_in_rdy stayed %b, required 1", flit_in_rdy);
        end
        @(posedge clk);
        #1;
        flit_in_val = 1'b0;
    endtask

    task automatic send_msg(input logic [FW-1:0] h, input logic [FW-1:0] a, input logic [FW-1:0] b);
        exp_q.push_back({b, a, h});
        send(h);
        send(a);
        send(b);
    endtask

    // Monitor: pops the scoreboard on every completed word transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (err_length) err_seen++;
                if (noc_out_val && noc_out_rdy) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %h expected no word", noc_out_data);
                    end else begin
                        check("word", noc_out_data, exp_q.pop_front());
                    end
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] h;
        logic [WW-1:0] w;
        int e0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_val", WW'(noc_out_val), '0);
        check("rst_rdy", WW'(flit_in_rdy), WW'(1));
        check("rst_err", WW'(err_length), '0);
        check("rst_data", noc_out_data, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single message with latency check
        h = mk_hdr(2, 16'h0001);
        exp_q.push_back({64'hB, 64'hA, h});
        send(h);
        send(64'hA);
        check("lat_before_last", WW'(noc_out_val), '0);
        send(64'hB);
        check("lat_val_rise", WW'(noc_out_val), WW'(1));
        repeat (2) @(posedge clk);
        #1;

        // Backpressure
        noc_out_rdy = 1'b0;
        h = mk_hdr(2, 16'h0002);
        w = {64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001, h};
        send_msg(h, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002);
        repeat (5) begin
            @(negedge clk);
            check("bp_val", WW'(noc_out_val), WW'(1));
            check("bp_rdy", WW'(flit_in_rdy), '0);
            check("bp_data", noc_out_data, w);
        end
        @(posedge clk);
        #1;
        noc_out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", WW'(flit_in_rdy), WW'(1));
        @(posedge clk);
        #1;

        // Back-to-back, second header presented in the FULL-exit cycle
        pop_cyc.delete();
        send_msg(mk_hdr(2, 16'h0003), 64'h3A, 64'h3B);
        send_msg(mk_hdr(2, 16'h0004), 64'h4A, 64'h4B);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_words", WW'(pop_cyc.size()), WW'(2));
        if (pop_cyc.size() >= 2) check("b2b_gap", WW'(pop_cyc[1] - pop_cyc[0]), WW'(3));

        // Bad length 4: header flagged, four flits dropped
        e0 = err_seen;
        send(mk_hdr(4, 16'h0005));
        check("bad4_err_pulse", WW'(err_length), WW'(1));
        send(mk_hdr(2, 16'h0DD1));
        check("bad4_err_single", WW'(err_length), '0);
        send(mk_hdr(2, 16'h0DD2));
        send(64'hDEAD);
        send(64'hBEEF);
        check("bad4_no_val", WW'(noc_out_val), '0);
        send_msg(mk_hdr(2, 16'h0006), 64'h6A, 64'h6B);
        repeat (2) @(posedge clk);
        #1;
        check("bad4_err_count", WW'(err_seen - e0), WW'(1));

        // Bad length 0: next flit is a header
        e0 = err_seen;
        send(mk_hdr(0, 16'h0007));
        check("bad0_err_pulse", WW'(err_length), WW'(1));
        send_msg(mk_hdr(2, 16'h0008), 64'h8A, 64'h8B);
        repeat (2) @(posedge clk);
        #1;
        check("bad0_err_count", WW'(err_seen - e0), WW'(1));

        // Reset after header and one payload flit
        send(mk_hdr(2, 16'h0009));
        send(64'h9A);
        rst_n = 1'b0;
        #1;
        check("mid_rst_val", WW'(noc_out_val), '0);
        check("mid_rst_rdy", WW'(flit_in_rdy), WW'(1));
        check("mid_rst_err", WW'(err_length), '0);
        check("mid_rst_data", noc_out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(mk_hdr(2, 16'h000A), 64'hAA, 64'hAB);
        repeat (3) @(posedge clk);
        #1;

        check("queue_drained", WW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_openpiton_flit_deserializer
`default_nettype wire

// File: doc/openpiton_flit_deserializer.md
# openpiton_flit_deserializer

- Receive-side front end for the xctcmsg OpenPiton path. Sits between the tile's OpenPiton NoC router port (FLIT_WIDTH-bit flits, val/rdy) and the adapter's `noc_in_*` port.
- Collects one header flit plus its payload flits and presents them as a single `PITON_XCTCMSG_NOC_WIDTH`-bit word laid out as {payload, header}.
- Performs length checking and discards malformed traffic so the adapter only ever sees complete messages.

## Interface

Parameters:
- FLIT_WIDTH, default 64: OpenPiton physical flit width. `XCTCMSG_MSG_HEADER_WIDTH` equals FLIT_WIDTH.
- PAYLOAD_FLITS, default `XCTCMSG_MSG_PAYLOAD_LENGTH`: expected payload flit count. Payload width is PAYLOAD_FLITS*FLIT_WIDTH.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flit_in_val  in  1  router flit valid.
- flit_in_rdy  out  1  deserializer accepts flit.
- flit_in_data  in  FLIT_WIDTH  flit.
- noc_out_val  out  1  assembled word valid, to adapter `noc_in_val`.
- noc_out_rdy  in  1  adapter ready.
- noc_out_data  out  `PITON_XCTCMSG_NOC_WIDTH`  {payload flits (flit 1 at LSB of payload), header}.
- err_length  out  1  one-cycle pulse when a header with a bad length field is accepted.

## Operation

- Transfer rule: a flit is transferred when flit_in_val && flit_in_rdy. A word is transferred when noc_out_val && noc_out_rdy.
- States: HEADER, PAYLOAD, DRAIN, FULL.
- HEADER:
  - flit_in_rdy=1.
  - On transfer, capture the header and read len = flit[`XCTCMSG_MSG_LENGTH`].
  - len==PAYLOAD_FLITS, nonzero: clear cnt and go to PAYLOAD.
  - len==PAYLOAD_FLITS==0: go to FULL.
  - len!=PAYLOAD_FLITS: pulse err_length the next cycle and do not latch the header. If len==0, stay in HEADER; otherwise load drop=len and go to DRAIN.
- PAYLOAD:
  - flit_in_rdy=1. Each transfer writes payload slot cnt and increments cnt.
  - The transfer with cnt==PAYLOAD_FLITS-1 moves to FULL.
- DRAIN:
  - flit_in_rdy=1. Each transfer decrements drop; data is discarded.
  - The transfer with drop==1 returns to HEADER. No word is produced.
- FULL:
  - noc_out_val=1 and the data register is held stable.
  - flit_in_rdy=noc_out_rdy, so a new header is accepted in the same cycle the word leaves. That header is then processed per the HEADER rules and the next state follows from it.
  - If noc_out_rdy=1 and no flit arrives, go to HEADER.
- Counter widths: cnt is $clog2(PAYLOAD_FLITS+1) bits. drop is the width of the `XCTCMSG_MSG_LENGTH` field. Neither wraps; both reload on each header.
- Unused payload slots are never visible, because a word is only emitted after all PAYLOAD_FLITS flits arrive.

## Timing

- Reset values: state=HEADER, noc_out_val=0, flit_in_rdy=1 (combinational from state), err_length=0, data register=0, cnt=0, drop=0.
- Latency: the header arrives in cycle 0, payload flits in cycles 1..N with no gaps, and noc_out_val is asserted in cycle N+1 (registered).
- Throughput: back-to-back messages need 1+N flit cycles each; there are no bubbles when noc_out_rdy is held high.
- Once noc_out_val is asserted, noc_out_data is stable until the transfer completes; noc_out_val never drops without a transfer.
- flit_in_rdy depends combinationally only on state and noc_out_rdy. There is no combinational path from flit_in_val to any output.
- Asynchronous reset mid-message discards the partial message. The next accepted flit is treated as a header.
- err_length is registered and high for exactly one cycle per bad header.

## Structure

- Shared package / `define.tmp.h`: `XCTCMSG_MSG_LENGTH` field, header and payload widths, `PITON_XCTCMSG_NOC_WIDTH`, and the state enum type `deser_state_t`.
- A single module. The payload store is a flat register with per-slot write enables; no sub-module is needed.
- The mirror transmit block, openpiton_flit_serializer, is a separate block that reuses the same package constants.

## Test plan

- Single message, PAYLOAD_FLITS=2, flits 0x...hdr(len=2), 0xA, 0xB, noc_out_rdy=1: noc_out_val rises in cycle 3, and data={0xB,0xA,hdr}.
- Backpressure: noc_out_rdy=0 for 5 cycles while FULL: flit_in_rdy=0 and data stable; when rdy rises, the transfer completes and flit_in_rdy=1 the same cycle.
- Back-to-back messages with a header presented in the FULL-exit cycle: no bubble, and the second word is presented 3 cycles after the first leaves.
- Bad length, header len=4 (expected 2): err_length pulses once, 4 flits are dropped, no noc_out_val; the following good message is assembled correctly.
- Bad length len=0: err_length pulses and the next flit is accepted as a header.
- Reset asserted after the header and 1 payload flit: outputs return to reset values immediately; a following full message produces the correct word.
